psram_qpi_responder: RTL and testbench

- Synthesizable responder-side model of the QPI PSRAM device that the PSRAM initiator talks to.
- Decodes the SPI reset/mode commands (66h, 99h, 35h) and the QPI read (EBh) and write (38h) transactions, backed by a small internal 16-bit word memory.
- Used as the memory stand-in on the bench and on-board loopback builds, so initiator timing can be checked without a physical PSRAM.

---
 rtl/psram_qpi_responder.sv | 118 +++++++++++
 tb/tb_psram_qpi_responder.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/psram_qpi_responder.sv
// psram_qpi_responder: QPI PSRAM device stand-in that decodes the SPI mode commands and the QPI EBh/38h transactions
// against a small 16-bit word memory, sampling and updating on rising mem_clk edges.
module psram_qpi_responder #(
    parameter int ADDR_BITS   = 8,
    parameter int WAIT_CYCLES = 6
) (
    input  logic       mem_clk,
    input  logic       rst_n,
    input  logic       mem_ce,
    input  logic [3:0] sio_in,
    output logic [3:0] sio_out,
    output logic [3:0] sio_oe,
    output logic       qpi_mode,
    output logic       rst_armed,
    output logic       wr_done,
    output logic       bad_cmd
);
    localparam int KW = $clog2(WAIT_CYCLES + 13);
    localparam logic [KW-1:0] K7     = KW'(7);
    localparam logic [KW-1:0] K11    = KW'(11);
    localparam logic [KW-1:0] K_LOAD = KW'(7 + WAIT_CYCLES);
    localparam logic [KW-1:0] K_END  = KW'(11 + WAIT_CYCLES);

    typedef enum logic [2:0] {IDLE, SPI_CMD, QPI_CMD, QPI_ADDR, QPI_WAIT, QPI_RDATA, QPI_WDATA, DISCARD} state_t;

    state_t               state;
    logic [KW-1:0]        k;
    logic [7:0]           cmd;
    logic [ADDR_BITS-1:0] addr;
    logic [11:0]          wdata;
    logic [11:0]          rdata;
    logic                 is_rd;
    logic [15:0]          mem [2**ADDR_BITS];
    logic [7:0]           cmd_byte;
    logic                 decode;
    logic                 qpi_rw;
    logic                 wr_en;

    // The byte as it stands once the current sample is folded in; only meaningful on the decode cycle.
    assign cmd_byte = qpi_mode ? {cmd[7:4], sio_in} : {cmd[6:0], sio_in[0]};
    assign decode   = !mem_ce && (state == QPI_CMD || (state == SPI_CMD && k == K7));
    assign qpi_rw   = qpi_mode && (cmd_byte == 8'hEB || cmd_byte == 8'h38);
    assign wr_en    = rst_n && !mem_ce && state == QPI_WDATA && k == K11;

    always_ff @(posedge mem_clk)
        if (wr_en) mem[addr] <= {wdata, sio_in};

    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            k         <= '0;
            cmd       <= '0;
            addr      <= '0;
            wdata     <= '0;
            rdata     <= '0;
            is_rd     <= 1'b0;
            sio_out   <= '0;
            sio_oe    <= '0;
            qpi_mode  <= 1'b0;
            rst_armed <= 1'b0;
            wr_done   <= 1'b0;
            bad_cmd   <= 1'b0;
        end else begin
            wr_done <= wr_en;
            bad_cmd <= 1'b0;
            if (mem_ce) begin
                state  <= IDLE;
                k      <= '0;
                sio_oe <= '0;
            end else begin
                k <= (&k) ? k : k + 1'b1;
                case (state)
                    IDLE: begin
                        cmd   <= qpi_mode ? {sio_in, 4'h0} : {7'h0, sio_in[0]};
                        state <= qpi_mode ? QPI_CMD : SPI_CMD;
                    end
                    SPI_CMD: cmd <= cmd_byte;
                    QPI_ADDR: begin
                        addr <= ADDR_BITS'({addr, sio_in});
                        if (k == K7) state <= is_rd ? QPI_WAIT : QPI_WDATA;
                    end
                    QPI_WDATA: begin
                        wdata <= {wdata[7:0], sio_in};
                        if (k == K11) state <= DISCARD;
                    end
                    QPI_WAIT: if (k == K_LOAD) begin
                        sio_oe            <= 4'hF;
                        {sio_out, rdata}  <= mem[addr];
                        state             <= QPI_RDATA;
                    end
                    QPI_RDATA: if (k == K_END) begin
                        sio_oe <= '0;
                        state  <= DISCARD;
                    end else begin
                        {sio_out, rdata} <= {rdata, 4'h0};
                    end
                    default: ;
                endcase
                if (decode) begin
                    case (cmd_byte)
                        8'h66: rst_armed <= 1'b1;
                        8'h99: begin
                            qpi_mode  <= qpi_mode && !rst_armed;
                            rst_armed <= 1'b0;
                        end
                        default: begin
                            rst_armed <= 1'b0;
                            if (!qpi_mode && cmd_byte == 8'h35) qpi_mode <= 1'b1;
                            else if (!qpi_rw) bad_cmd <= 1'b1;
                        end
                    endcase
                    is_rd <= cmd_byte == 8'hEB;
                    state <= qpi_rw ? QPI_ADDR : DISCARD;
                end
            end
        end
    end
endmodule

// File: tb/tb_psram_qpi_responder.sv
// tb_psram_qpi_responder: directed transactions against a transaction-level model of the PSRAM responder,
// checked every cycle, plus literal expectations on the words read back.
module tb_psram_qpi_responder;
    localparam int W = 6;

    logic       mem_clk = 1'b0;
    logic       rst_n   = 1'b1;
    logic       mem_ce  = 1'b1;
    logic [3:0] sio_in  = 4'h0;
    logic [3:0] sio_out;
    logic [3:0] sio_oe;
    logic       qpi_mode;
    logic       rst_armed;
    logic       wr_done;
    logic       bad_cmd;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] m_mem [256];
    bit          m_qpi = 0;
    bit          m_armed = 0;
    logic [3:0]  e_oe = 4'h0;
    logic [3:0]  e_out = 4'h0;
    bit          e_wr = 0;
    bit          e_bad = 0;
    bit          chk_en = 0;
    logic [15:0] rd_word = 16'h0;
    int          wr_seen = 0;
    int          wr_before;

    psram_qpi_responder #(.ADDR_BITS(8), .WAIT_CYCLES(W)) dut (
        .mem_clk(mem_clk), .rst_n(rst_n), .mem_ce(mem_ce), .sio_in(sio_in),
        .sio_out(sio_out), .sio_oe(sio_oe), .qpi_mode(qpi_mode), .rst_armed(rst_armed),
        .wr_done(wr_done), .bad_cmd(bad_cmd)
    );

    always #5 mem_clk = ~mem_clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge mem_clk) begin
        #1;
        if (chk_en) begin
            chk("sio_oe", sio_oe, e_oe);
            if (e_oe != 4'h0) begin
                chk("sio_out", sio_out, e_out);
                rd_word = {rd_word[11:0], sio_out};
            end
            chk("qpi_mode", qpi_mode, m_qpi);
            chk("rst_armed", rst_armed, m_armed);
            chk("wr_done", wr_done, e_wr);
            chk("bad_cmd", bad_cmd, e_bad);
            if (wr_done) wr_seen++;
        end
    end

    task automatic model_decode(input logic [7:0] c);
        if (c == 8'h66) m_armed = 1;
        else if (c == 8'h99) begin
            if (m_armed) m_qpi = 0;
            m_armed = 0;
        end else begin
            m_armed = 0;
            if (!m_qpi && c == 8'h35) m_qpi = 1;
            else if (!(m_qpi && (c == 8'hEB || c == 8'h38))) e_bad = 1;
        end
    endtask

    // One chip-select frame of len rising edges; rst_k pulses rst_n just after that edge.
    task automatic run(input logic [7:0] c, input logic [23:0] a, input logic [15:0] d, input int len, input int rst_k = -1);
        bit          qpi = m_qpi;
        int          idx = int'(a[7:0]);
        logic [15:0] t;
        rd_word = 16'h0;
        for (int k = 0; k < len; k++) begin
            @(negedge mem_clk);
            mem_ce = 1'b0;
            if (!qpi) sio_in = (k < 8) ? {3'b0, c[7-k]} : 4'h0;
            else sio_in = (k < 2) ? c[7-4*k -: 4] : (k < 8) ? a[23-4*(k-2) -: 4] : (k < 12) ? d[15-4*(k-8) -: 4] : 4'h6;
            e_bad = 0;
            e_wr  = 0;
            e_oe  = 4'h0;
            if ((!qpi && k == 7) || (qpi && k == 1)) model_decode(c);
            if (qpi && c == 8'h38 && k == 11) begin
                e_wr = 1;
                m_mem[idx] = d;
            end
            if (qpi && c == 8'hEB && k >= W + 7 && k <= W + 10) begin
                e_oe  = 4'hF;
                t     = m_mem[idx] >> (4 * (W + 10 - k));
                e_out = t[3:0];
            end
            if (k == rst_k) begin
                @(posedge mem_clk);
                #3 rst_n = 1'b0;
                #1;
                chk("rst_sio_oe", sio_oe, 16'h0);
                chk("rst_qpi_mode", qpi_mode, 16'h0);
                chk("rst_rst_armed", rst_armed, 16'h0);
                m_qpi   = 0;
                m_armed = 0;
                break;
            end
        end
        @(negedge mem_clk);
        mem_ce = 1'b1;
        rst_n  = 1'b1;
        e_oe   = 4'h0;
        e_wr   = 0;
        e_bad  = 0;
        @(negedge mem_clk);
    endtask

    initial begin
        #3 rst_n = 1'b0;
        repeat (2) @(negedge mem_clk);
        chk("reset_sio_oe", sio_oe, 16'h0);
        chk("reset_sio_out", sio_out, 16'h0);
        chk("reset_qpi_mode", qpi_mode, 16'h0);
        chk("reset_wr_done", wr_done, 16'h0);
        chk("reset_bad_cmd", bad_cmd, 16'h0);
        rst_n  = 1'b1;
        chk_en = 1;
        @(negedge mem_clk);

        run(8'h99, 24'h0, 16'h0, 10);
        chk("unarmed_99_ignored", qpi_mode, 16'h0);
        run(8'h66, 24'h0, 16'h0, 10);
        chk("armed_after_66", rst_armed, 16'h1);
        run(8'h99, 24'h0, 16'h0, 10);
        chk("disarmed_after_99", rst_armed, 16'h0);
        run(8'h35, 24'h0, 16'h0, 10);
        chk("qpi_after_35", qpi_mode, 16'h1);

        run(8'h38, 24'h000012, 16'hA5C3, 12);
        chk("wr_pulse_count", wr_seen, 16'h1);
        run(8'hEB, 24'h000012, 16'h0, 18);
        chk("read_12", rd_word, 16'hA5C3);

        run(8'h38, 24'h000105, 16'h1234, 12);
        run(8'hEB, 24'h000005, 16'h0, 18);
        chk("read_alias_05", rd_word, 16'h1234);

        run(8'h38, 24'h000020, 16'hBEEF, 12);
        wr_before = wr_seen;
        run(8'h38, 24'h000020, 16'h0F0F, 10);
        chk("abort_no_wr_done", wr_seen, 16'(wr_before));
        run(8'hEB, 24'h000020, 16'h0, 18);
        chk("read_after_abort", rd_word, 16'hBEEF);

        run(8'h5A, 24'h0, 16'h0, 4);
        run(8'h66, 24'h0, 16'h0, 4);
        run(8'h99, 24'h0, 16'h0, 4);
        chk("qpi_exit", qpi_mode, 16'h0);
        run(8'h5A, 24'h0, 16'h0, 10);
        chk("spi_bad_keeps_mode", qpi_mode, 16'h0);
        run(8'h35, 24'h0, 16'h0, 10);
        chk("qpi_reentered", qpi_mode, 16'h1);

        run(8'hEB, 24'h000012, 16'h0, 18, 15);
        run(8'h35, 24'h0, 16'h0, 10);
        run(8'hEB, 24'h000012, 16'h0, 18);
        chk("read_after_rst", rd_word, 16'hA5C3);

        chk_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
